// File: rtl/roll_ctrl.sv
// roll_ctrl: debounced roll button, dice spinner and valid/ack handoff
// to the craps game FSM.
module roll_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SPIN_DIV        = 4
) (
  input  logic       Clk100MHz,
  input  logic       reset_n,
  input  logic       roll_btn,
  input  logic       fsm_ready,
  input  logic       roll_ack,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       roll_valid,
  output logic       spinning
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SPIN_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    SPIN,
    REL_DB,
    PRESENT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tick, tick_n;
  logic          sync1, btn_s;
  logic          adv;
  logic [2:0]    d1_n, d2_n;

  always_ff @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= roll_btn;
      btn_s <= sync1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tick_n  = tick;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fsm_ready && btn_s) begin
          state_n = PRESS_DB;
          cnt_n   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = SPIN;
          cnt_n   = '0;
          tick_n  = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SPIN: begin
        adv    = (tick == TICK_LAST);
        tick_n = adv ? '0 : tick + TW'(1);
        if (!btn_s) begin
          state_n = REL_DB;
          cnt_n   = '0;
        end
      end
      REL_DB: begin
        // tick is left alone so a bounce resumes the spin mid-period
        if (btn_s) begin
          state_n = SPIN;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = PRESENT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESENT: begin
        if (roll_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    d1_n = (die1 == 3'd6) ? 3'd1 : die1 + 3'd1;
    d2_n = die2;
    if (die1 == 3'd6) d2_n = (die2 == 3'd6) ? 3'd1 : die2 + 3'd1;
  end

  always_ff @(posedge Clk100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tick       <= '0;
      die1       <= 3'd1;
      die2       <= 3'd1;
      sum        <= 4'd2;
      spinning   <= 1'b0;
      roll_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tick       <= tick_n;
      spinning   <= (state_n == SPIN);
      roll_valid <= (state_n == PRESENT);
      if (adv) begin
        die1 <= d1_n;
        die2 <= d2_n;
        sum  <= {1'b0, d1_n} + {1'b0, d2_n};
      end
    end
  end

endmodule
